// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter driving the select/enable of a shared 4:1 tri-state mux.
// Define MUX4_ARB_GAP_EN to force a one-cycle bus-turnaround GAP after every tenure.
module mux4_rr_arbiter #(
  parameter int MAX_HOLD = 8,
  parameter int HOLD_W   = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  output logic [3:0] gnt,
  output logic [1:0] mux_sel,
  output logic       mux_en,
  output logic       busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    GAP   = 2'd2
  } state_t;

  state_t            state_reg, state_next;
  logic [3:0]        gnt_reg, gnt_next;
  logic [1:0]        sel_reg, sel_next;
  logic [1:0]        ptr_reg, ptr_next;
  logic [HOLD_W-1:0] hold_reg, hold_next;

  logic [2:0]        win_idle;
  logic [1:0]        rel_ptr;
`ifndef MUX4_ARB_GAP_EN
  logic [2:0]        win_rel;
`endif

  // Returns {found, index} of the first set request starting at start.
  function automatic logic [2:0] pick(input logic [1:0] start, input logic [3:0] r);
    logic [2:0] res;
    logic [1:0] idx;
    res = 3'b000;
    for (int k = 0; k < 4; k++) begin
      idx = start + 2'(k);
      if (!res[2] && r[idx]) res = {1'b1, idx};
    end
    return res;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      gnt_reg   <= 4'b0000;
      sel_reg   <= 2'b00;
      ptr_reg   <= 2'b00;
      hold_reg  <= '0;
    end else begin
      state_reg <= state_next;
      gnt_reg   <= gnt_next;
      sel_reg   <= sel_next;
      ptr_reg   <= ptr_next;
      hold_reg  <= hold_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    gnt_next   = gnt_reg;
    sel_next   = sel_reg;
    ptr_next   = ptr_reg;
    hold_next  = hold_reg;
    win_idle   = pick(ptr_reg, req);
    rel_ptr    = sel_reg + 2'd1;
`ifndef MUX4_ARB_GAP_EN
    win_rel    = pick(rel_ptr, req);
`endif
    case (state_reg)
      IDLE, GAP: begin
        if (win_idle[2]) begin
          state_next = GRANT;
          gnt_next   = 4'b0001 << win_idle[1:0];
          sel_next   = win_idle[1:0];
          hold_next  = HOLD_W'(1);
        end else begin
          state_next = IDLE;
          gnt_next   = 4'b0000;
        end
      end
      GRANT: begin
        if (req[sel_reg] && (hold_reg < HOLD_W'(MAX_HOLD))) begin
          hold_next = hold_reg + HOLD_W'(1);
        end else begin
          // Release: the owner drops to lowest priority for the next decision.
          ptr_next = rel_ptr;
`ifdef MUX4_ARB_GAP_EN
          state_next = GAP;
          gnt_next   = 4'b0000;
          hold_next  = '0;
`else
          if (win_rel[2]) begin
            gnt_next  = 4'b0001 << win_rel[1:0];
            sel_next  = win_rel[1:0];
            hold_next = HOLD_W'(1);
          end else begin
            state_next = IDLE;
            gnt_next   = 4'b0000;
            hold_next  = '0;
          end
`endif
        end
      end
      default: begin
        state_next = IDLE;
        gnt_next   = 4'b0000;
        hold_next  = '0;
      end
    endcase
  end

  always_comb begin
    gnt     = gnt_reg;
    mux_sel = sel_reg;
    mux_en  = |gnt_reg;
    busy    = |gnt_reg;
  end

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Randomized self-checking bench for mux4_rr_arbiter against a tenure-level reference model.
module tb_mux4_rr_arbiter;
  localparam int MAX_HOLD = 8;

  logic       clk;
  logic       rst;
  logic [3:0] req;
  logic [3:0] gnt;
  logic [1:0] mux_sel;
  logic       mux_en;
  logic       busy;

  int checks = 0;
  int errors = 0;

  // Reference model: owner index (-1 = bus free), rotation pointer, tenure length.
  int m_owner = -1;
  int m_ptr   = 0;
  int m_hold  = 0;
  int m_sel   = 0;
  int zero_cycles;

  mux4_rr_arbiter #(.MAX_HOLD(MAX_HOLD), .HOLD_W(4)) dut (
    .clk(clk), .rst(rst), .req(req), .gnt(gnt),
    .mux_sel(mux_sel), .mux_en(mux_en), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("FAIL %s: observed=%0h expected=%0h at t=%0t", tag, observed, expected, $time);
    end
  endtask

  function automatic int first_from(input int start, input logic [3:0] r);
    for (int k = 0; k < 4; k++) begin
      if (r[(start + k) % 4]) return (start + k) % 4;
    end
    return -1;
  endfunction

  task automatic model_step(input logic [3:0] r, input logic rs);
    int w;
    if (rs) begin
      m_owner = -1; m_ptr = 0; m_hold = 0; m_sel = 0;
    end else if (m_owner < 0) begin
      w = first_from(m_ptr, r);
      if (w >= 0) begin
        m_owner = w; m_sel = w; m_hold = 1;
      end
    end else if (r[m_owner] && m_hold < MAX_HOLD) begin
      m_hold++;
    end else begin
      m_ptr = (m_owner + 1) % 4;
`ifdef MUX4_ARB_GAP_EN
      m_owner = -1;
`else
      w = first_from(m_ptr, r);
      m_owner = w;
      if (w >= 0) begin
        m_sel = w; m_hold = 1;
      end
`endif
    end
  endtask

  task automatic tick(input logic [3:0] r, input logic rs);
    logic [3:0] exp_gnt;
    @(negedge clk);
    req = r;
    rst = rs;
    model_step(r, rs);
    @(posedge clk);
    #1;
    exp_gnt = (m_owner < 0) ? 4'b0000 : (4'b0001 << m_owner);
    check("gnt", 32'(gnt), 32'(exp_gnt));
    check("mux_en", 32'(mux_en), 32'(m_owner >= 0));
    check("busy", 32'(busy), 32'(m_owner >= 0));
    check("mux_sel", 32'(mux_sel), 32'(m_sel));
    $display("req=%b rst=%b gnt=%b sel=%0d en=%b", r, rs, gnt, mux_sel, mux_en);
  endtask

  initial begin
    rst = 1'b1;
    req = 4'b0000;

    // Reset with everybody requesting, then first grant goes to requester 0.
    tick(4'b1111, 1'b1);
    tick(4'b1111, 1'b1);
    check("reset_gnt", 32'(gnt), 32'h0);
    tick(4'b1111, 1'b0);
    check("first_gnt", 32'(gnt), 32'h1);

    // Rotation under full load.
    zero_cycles = 0;
    for (int i = 0; i < 40; i++) begin
      tick(4'b1111, 1'b0);
      if (gnt == 4'b0000) zero_cycles++;
    end
`ifndef MUX4_ARB_GAP_EN
    check("rotation_no_gap", 32'(zero_cycles), 32'd0);
`endif

    // Single requester held for 20 cycles, then dropped.
    tick(4'b0000, 1'b1);
    for (int i = 0; i < 20; i++) tick(4'b0100, 1'b0);
`ifndef MUX4_ARB_GAP_EN
    check("single_hold", 32'(gnt), 32'h4);
`endif
    tick(4'b0000, 1'b0);
    check("single_drop", 32'(gnt), 32'h0);

    // Early release: owner 1 drops after 3 cycles while 0 and 3 request.
    tick(4'b0000, 1'b1);
    tick(4'b0010, 1'b0);
    tick(4'b0010, 1'b0);
    tick(4'b0010, 1'b0);
    tick(4'b1001, 1'b0);
`ifdef MUX4_ARB_GAP_EN
    tick(4'b1001, 1'b0);
`endif
    check("early_release_gnt", 32'(gnt), 32'h8);
    check("early_release_sel", 32'(mux_sel), 32'd3);

    // Reset mid-grant clears at that edge and restarts the pointer at 0.
    tick(4'b0000, 1'b1);
    for (int i = 0; i < 5; i++) tick(4'b0100, 1'b0);
    tick(4'b0100, 1'b1);
    check("mid_reset_gnt", 32'(gnt), 32'h0);
    tick(4'b1111, 1'b0);
    check("post_reset_gnt", 32'(gnt), 32'h1);

    // Random traffic with occasional resets.
    for (int i = 0; i < 3000; i++) begin
      tick(4'($urandom_range(0, 15)), ($urandom_range(0, 99) == 0));
    end
    // Biased traffic: mostly-held requests to exercise hold-limit releases.
    for (int i = 0; i < 1000; i++) begin
      tick((($urandom_range(0, 7) == 0) ? 4'($urandom_range(0, 15)) : req), 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
